trap_ctrl_unit: RTL
===================

// Module: trap_ctrl_unit
// PURPOSE
//  Parametrised M-mode trap controller for the 5-stage core, MEM/WB boundary. Holds machine CSRs, arbitrates
//  sync exceptions and NUM_IRQ synchronised interrupts, and updates mepc/mcause/mtval/mstatus on trap entry.
//  Runs a registered two-phase flush/redirect FSM for trap entry and mret.
// PARAMETERS
//  XLEN         32  data/PC width
//  NUM_IRQ      4   local interrupt lines (1..16), cause = 16+i, mie/mip bit 16+i
//  SYNC_STAGES  2   flop stages on each irq_in line (>=1)
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous reset, active-low
//  csr_rw_in        in   1        CSR instruction in MEM
//  csr_wsc_mode_in  in   2        01 write, 10 set, 11 clear (inst[13:12])
//  csr_w_imm_mux    in   1        1: source is zero-extended csr_w_data_imm
//  csr_rw_addr_in   in   12       CSR address
//  csr_w_data_reg   in   XLEN     rs1 data
//  csr_w_data_imm   in   5        zimm
//  csr_r_data_out   out  XLEN     CSR read data (old value), combinational
//  irq_in           in   NUM_IRQ  async level interrupt requests
//  illegal_inst, ecall_m, l_access_fault, s_access_fault, mret  in 1 each  MEM-stage events
//  fault_addr       in   XLEN     faulting data address (mtval source)
//  epc_cur          in   XLEN     PC of excepting instruction
//  epc_next         in   XLEN     oldest un-flushed PC (interrupt return point)
//  PC_redirect      out  XLEN     registered redirect target
//  redirect_mux     out  1        select PC_redirect
//  reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush  out 1 each
//  RegWrite_cancel  out  1        kill WB write of excepting instruction
//  trap_busy        out  1        FSM in FLUSH
// BEHAVIOUR
//  CSRs: mstatus(300, MIE b3, MPIE b7, MPP b12:11 =2'b11), mie(304), mtvec(305), mscratch(340), mepc(341, b1:0=0),
//   mcause(342), mtval(343), mip(344, read-only = synced irq at 16+i). Unimplemented addr: read 0, write ignored.
//  Reset (rst=0 at edge): all CSRs 0 except MPP=11; sync flops 0; state IDLE; PC_redirect 0; all outputs 0.
//  CSR write: set/clear with zero source (rs1 value 0 or zimm 0) does not write. Write is suppressed whenever a
//   trap or mret is accepted in the same cycle.
//  Sync priority: illegal(2) > ecall_m(11) > l_access_fault(5) > s_access_fault(7). mtval = fault_addr for
//   5/7, else 0. mepc = epc_cur.
//  Interrupt: pend = mip & mie; taken if MIE=1, pend!=0, no sync exception and no mret; lowest i wins.
//   mcause={1'b1, 16+i}, mepc=epc_next, mtval=0. Sync exception always beats interrupt.
//  FSM IDLE: on accepted trap -> RegWrite_cancel=1 (sync only) this cycle; at edge write CSRs, MPIE<=MIE,
//   MIE<=0, latch target, -> FLUSH. On mret: at edge MIE<=MPIE, MPIE<=1, target<=mepc, -> FLUSH.
//  FSM FLUSH (exactly 1 cycle): redirect_mux, all four flushes, trap_busy = 1; every event input ignored
//   (not queued); -> IDLE. Back-to-back trap possible from the cycle after FLUSH.
//  Target: {mtvec[XLEN-1:2],2'b00}; mret: mepc.
//  Reset mid-FLUSH: returns to IDLE next edge, no redirect issued afterwards.
//  irq_in seen SYNC_STAGES cycles after assertion; deassertion before sampling loses it (level semantics).
// CONFIGURATION
//  TRAP_VECTORED_EN defined: mtvec[1:0]=01 -> interrupts target base+4*cause[4:0]; exceptions use base;
//   mtvec[1:0] stored as written (bit1 forced 0). Undefined: mtvec[1:0] hardwired 00, always direct.
// TESTING
//  mtvec=0x100, illegal_inst with epc_cur=0x40 -> RegWrite_cancel same cycle; next cycle redirect 0x100,
//   flushes=1; mepc=0x40, mcause=2, mtval=0.
//  l_access_fault+s_access_fault together, fault_addr=0xDEAD0000 -> mcause=5, mtval=0xDEAD0000.
//  MIE=1, mie[17]=1, irq_in[1]=1, epc_next=0x88 -> after SYNC_STAGES cycles trap; mcause=0x80000011,
//   mepc=0x88, MIE=0, MPIE=1; with TRAP_VECTORED_EN and mtvec=0x101, target 0x144.
//  mret with mepc=0x88, MPIE=1 -> next cycle redirect 0x88; MIE=1, MPIE=1.
//  csrrs mscratch with rs1 value 0 -> no write; csrrw same cycle as ecall_m -> write dropped, mcause=11.
//  illegal_inst asserted during FLUSH -> ignored; rst low during FLUSH -> IDLE, outputs 0, CSRs reset.

Source files
------------

// File: rtl/trap_ctrl_unit.sv
// M-mode trap controller: machine CSRs, exception/interrupt arbitration and a two-phase flush/redirect FSM.
// Build option: define TRAP_VECTORED_EN to enable vectored interrupt dispatch (mtvec mode 01).
module trap_ctrl_unit #(
    parameter int XLEN        = 32,
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_rw_in,
    input  logic [1:0]         csr_wsc_mode_in,
    input  logic               csr_w_imm_mux,
    input  logic [11:0]        csr_rw_addr_in,
    input  logic [XLEN-1:0]    csr_w_data_reg,
    input  logic [4:0]         csr_w_data_imm,
    output logic [XLEN-1:0]    csr_r_data_out,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               illegal_inst,
    input  logic               ecall_m,
    input  logic               l_access_fault,
    input  logic               s_access_fault,
    input  logic               mret,
    input  logic [XLEN-1:0]    fault_addr,
    input  logic [XLEN-1:0]    epc_cur,
    input  logic [XLEN-1:0]    epc_next,
    output logic [XLEN-1:0]    PC_redirect,
    output logic               redirect_mux,
    output logic               reg_FD_flush,
    output logic               reg_DE_flush,
    output logic               reg_EM_flush,
    output logic               reg_MW_flush,
    output logic               RegWrite_cancel,
    output logic               trap_busy
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [XLEN-1:0] ALIGN4_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`ifdef TRAP_VECTORED_EN
    localparam logic [XLEN-1:0] MTVEC_MASK  = {{(XLEN-2){1'b1}}, 2'b01};
`else
    localparam logic [XLEN-1:0] MTVEC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
`endif

    typedef enum logic {
        IDLE,
        FLUSH
    } trapState_t;

    trapState_t state_q, state_d;

    logic               mstatusMie_q, mstatusMpie_q;
    logic [XLEN-1:0]    mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0]    pcRedirect_q;
    logic [NUM_IRQ-1:0] irqSync_q [SYNC_STAGES];

    logic [XLEN-1:0]    mipVal, readVal, srcVal, wrVal;
    logic [XLEN-1:0]    mtvecBase, irqTarget;
    logic [NUM_IRQ-1:0] irqPend;
    logic [4:0]         irqCode;
    logic [3:0]         excCode;
    logic               irqAny, syncExc;
    logic               takeExc, takeIrq, takeMret, csrWe;

    // Level-sensitive interrupt lines pass through a plain flop chain; a pulse shorter than a cycle may be lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) irqSync_q[s] <= '0;
        end else begin
            irqSync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) irqSync_q[s] <= irqSync_q[s-1];
        end
    end

    always_comb begin
        mipVal = '0;
        mipVal[16 +: NUM_IRQ] = irqSync_q[SYNC_STAGES-1];
    end

    assign irqPend = mipVal[16 +: NUM_IRQ] & mie_q[16 +: NUM_IRQ];
    assign irqAny  = |irqPend;

    always_comb begin
        irqCode = 5'd16;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irqPend[i]) irqCode = 5'(16 + i);
        end
    end

    assign syncExc = illegal_inst | ecall_m | l_access_fault | s_access_fault;

    always_comb begin
        if (illegal_inst)        excCode = 4'd2;
        else if (ecall_m)        excCode = 4'd11;
        else if (l_access_fault) excCode = 4'd5;
        else                     excCode = 4'd7;
    end

    always_comb begin
        readVal = '0;
        case (csr_rw_addr_in)
            ADDR_MSTATUS: begin
                readVal[12:11] = 2'b11;
                readVal[7]     = mstatusMpie_q;
                readVal[3]     = mstatusMie_q;
            end
            ADDR_MIE:      readVal = mie_q;
            ADDR_MTVEC:    readVal = mtvec_q;
            ADDR_MSCRATCH: readVal = mscratch_q;
            ADDR_MEPC:     readVal = mepc_q;
            ADDR_MCAUSE:   readVal = mcause_q;
            ADDR_MTVAL:    readVal = mtval_q;
            ADDR_MIP:      readVal = mipVal;
            default:       readVal = '0;
        endcase
    end

    assign csr_r_data_out = readVal;
    assign srcVal = csr_w_imm_mux ? {{(XLEN-5){1'b0}}, csr_w_data_imm} : csr_w_data_reg;

    always_comb begin
        case (csr_wsc_mode_in)
            2'b01:   wrVal = srcVal;
            2'b10:   wrVal = readVal | srcVal;
            2'b11:   wrVal = readVal & ~srcVal;
            default: wrVal = readVal;
        endcase
    end

    assign mtvecBase = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign irqTarget = (mtvec_q[1:0] == 2'b01)
                     ? mtvecBase + {{(XLEN-7){1'b0}}, irqCode, 2'b00}
                     : mtvecBase;
`else
    assign irqTarget = mtvecBase;
`endif

    always_comb begin
        state_d         = state_q;
        takeExc         = 1'b0;
        takeIrq         = 1'b0;
        takeMret        = 1'b0;
        redirect_mux    = 1'b0;
        reg_FD_flush    = 1'b0;
        reg_DE_flush    = 1'b0;
        reg_EM_flush    = 1'b0;
        reg_MW_flush    = 1'b0;
        trap_busy       = 1'b0;
        RegWrite_cancel = 1'b0;
        case (state_q)
            IDLE: begin
                takeExc         = syncExc;
                takeMret        = mret & ~syncExc;
                takeIrq         = mstatusMie_q & irqAny & ~syncExc & ~mret;
                RegWrite_cancel = syncExc & rst;
                if (takeExc || takeMret || takeIrq) state_d = FLUSH;
            end
            FLUSH: begin
                redirect_mux = 1'b1;
                reg_FD_flush = 1'b1;
                reg_DE_flush = 1'b1;
                reg_EM_flush = 1'b1;
                reg_MW_flush = 1'b1;
                trap_busy    = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The instruction in MEM during FLUSH is younger than the trap and is being squashed, so it may not write CSRs.
    assign csrWe = (state_q == IDLE) && csr_rw_in && (csr_wsc_mode_in != 2'b00)
                && !(csr_wsc_mode_in[1] && (srcVal == '0))
                && !takeExc && !takeIrq && !takeMret;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            mstatusMie_q  <= 1'b0;
            mstatusMpie_q <= 1'b0;
            mie_q         <= '0;
            mtvec_q       <= '0;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            pcRedirect_q  <= '0;
        end else begin
            state_q <= state_d;
            if (takeExc) begin
                mepc_q        <= epc_cur & ALIGN4_MASK;
                mcause_q      <= {{(XLEN-4){1'b0}}, excCode};
                mtval_q       <= (excCode == 4'd5 || excCode == 4'd7) ? fault_addr : '0;
                mstatusMpie_q <= mstatusMie_q;
                mstatusMie_q  <= 1'b0;
                pcRedirect_q  <= mtvecBase;
            end else if (takeIrq) begin
                mepc_q        <= epc_next & ALIGN4_MASK;
                mcause_q      <= {1'b1, {(XLEN-6){1'b0}}, irqCode};
                mtval_q       <= '0;
                mstatusMpie_q <= mstatusMie_q;
                mstatusMie_q  <= 1'b0;
                pcRedirect_q  <= irqTarget;
            end else if (takeMret) begin
                mstatusMie_q  <= mstatusMpie_q;
                mstatusMpie_q <= 1'b1;
                pcRedirect_q  <= mepc_q;
            end else if (csrWe) begin
                case (csr_rw_addr_in)
                    ADDR_MSTATUS: begin
                        mstatusMie_q  <= wrVal[3];
                        mstatusMpie_q <= wrVal[7];
                    end
                    ADDR_MIE:      mie_q      <= wrVal;
                    ADDR_MTVEC:    mtvec_q    <= wrVal & MTVEC_MASK;
                    ADDR_MSCRATCH: mscratch_q <= wrVal;
                    ADDR_MEPC:     mepc_q     <= wrVal & ALIGN4_MASK;
                    ADDR_MCAUSE:   mcause_q   <= wrVal;
                    ADDR_MTVAL:    mtval_q    <= wrVal;
                    default: ;
                endcase
            end
        end
    end

    assign PC_redirect = pcRedirect_q;

endmodule
